// File: rtl/bus_rr_arbiter.sv
// bus_rr_arbiter
// ----------------------------------------------------------------------------
// Round-robin owner arbitration for the single system-bus master port.
//
// The arbiter looks at `request` only while it is idle. It grants one master
// and then follows that master's transaction until it closes. Only after that
// does it arbitrate again. The search starts at a rotating priority pointer,
// so the master that was just served has the lowest priority next time.
//
// Ports
//   clock                 system clock, rising edge
//   reset                 asynchronous, active-high
//   request[N]            per-master request, held high until granted
//   begin_transaction_in  begin from the granted master
//   end_transaction_in    end from master or slave
//   error_in              bus error
//   granted[N]            one-hot, one-cycle grant pulse (registered)
//   active_master         index of the current owner, valid while bus_busy
//   bus_busy              high from the grant pulse until the transaction closes
//   end_transaction_out   one-cycle forced end on watchdog abort
//   timeout_error         one-cycle pulse on watchdog abort
//   dbg_state_o           FSM state (0 IDLE, 1 GRANT, 2 WAIT_BEGIN, 3 BUSY)
//   dbg_ptr_o             round-robin priority pointer
//
// Handshake: a master holds request[m] high until it sees granted[m] for one
// cycle. It then has BEGIN_WINDOW cycles to assert begin_transaction_in. The
// bus stays owned until end_transaction_in or error_in is sampled. Requests
// that arrive while the bus is owned, including one from the owner, wait for
// the next arbitration.
//
// Optional feature macro: BUS_ARB_TIMEOUT_EN adds a BUSY-state watchdog of
// TIMEOUT_CYCLES cycles. Without it, both abort outputs are tied low.
// ----------------------------------------------------------------------------
module bus_rr_arbiter #(
   parameter int NUM_MASTERS    = 4,
   parameter int BEGIN_WINDOW   = 4,
   parameter int TIMEOUT_CYCLES = 256
) (
   input  logic                           clock,
   input  logic                           reset,
   input  logic [NUM_MASTERS-1:0]         request,
   input  logic                           begin_transaction_in,
   input  logic                           end_transaction_in,
   input  logic                           error_in,
   output logic [NUM_MASTERS-1:0]         granted,
   output logic [$clog2(NUM_MASTERS)-1:0] active_master,
   output logic                           bus_busy,
   output logic                           end_transaction_out,
   output logic                           timeout_error,
   output logic [1:0]                     dbg_state_o,
   output logic [$clog2(NUM_MASTERS)-1:0] dbg_ptr_o
);

   localparam int IDX_W = $clog2(NUM_MASTERS);
   localparam int EXT_W = IDX_W + 1;
   localparam int BW_W  = $clog2(BEGIN_WINDOW + 1);
   localparam logic [EXT_W-1:0] N_EXT   = EXT_W'(NUM_MASTERS);
   localparam logic [BW_W-1:0]  BW_LAST = BW_W'(BEGIN_WINDOW - 1);

   // An out-of-range parameter set elaborates this empty marker block, which
   // makes a bad configuration easy to spot in the hierarchy.
   if (NUM_MASTERS < 2 || NUM_MASTERS > 8 || BEGIN_WINDOW < 1 ||
       TIMEOUT_CYCLES < 1) begin : g_bad_params
   end

   typedef enum logic [1:0] {
      S_IDLE       = 2'd0,
      S_GRANT      = 2'd1,
      S_WAIT_BEGIN = 2'd2,
      S_BUSY       = 2'd3
   } state_t;

   state_t                 state_q, state_d;
   logic [IDX_W-1:0]       ptr_q, ptr_d;
   logic [IDX_W-1:0]       owner_q, owner_d;
   logic [NUM_MASTERS-1:0] grant_q, grant_d;
   logic                   busy_q, busy_d;
   logic [BW_W-1:0]        bcnt_q, bcnt_d;

`ifdef BUS_ARB_TIMEOUT_EN
   localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);
   logic [WD_W-1:0]        wd_q, wd_d;
   logic                   abort_q, abort_d;
`endif

   // Rotating search. The candidate index is formed one bit wider, so
   // ptr + i can be folded back below NUM_MASTERS without wrapping early.
   logic [EXT_W-1:0] cand;
   logic [EXT_W-1:0] next_ext;
   logic             pick_found;
   logic [IDX_W-1:0] pick_idx;
   logic [IDX_W-1:0] pick_next;

   always_comb begin
      pick_found = 1'b0;
      pick_idx   = '0;
      cand       = '0;
      for (int i = 0; i < NUM_MASTERS; i++) begin
         cand = {1'b0, ptr_q} + EXT_W'(i);
         if (cand >= N_EXT) cand = cand - N_EXT;
         if (!pick_found && request[cand[IDX_W-1:0]]) begin
            pick_found = 1'b1;
            pick_idx   = cand[IDX_W-1:0];
         end
      end
      next_ext = {1'b0, pick_idx} + EXT_W'(1);
      if (next_ext >= N_EXT) next_ext = '0;
      pick_next = next_ext[IDX_W-1:0];
   end

   // Both counters default to zero. Each one therefore clears whenever its
   // state is left and never counts past its limit.
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      owner_d = owner_q;
      grant_d = '0;
      busy_d  = busy_q;
      bcnt_d  = '0;
`ifdef BUS_ARB_TIMEOUT_EN
      wd_d    = '0;
      abort_d = 1'b0;
`endif
      case (state_q)
         S_IDLE: begin
            if (pick_found) begin
               grant_d = NUM_MASTERS'(1) << pick_idx;
               owner_d = pick_idx;
               ptr_d   = pick_next;
               busy_d  = 1'b1;
               state_d = S_GRANT;
            end
         end
         S_GRANT: begin
            state_d = S_WAIT_BEGIN;
         end
         S_WAIT_BEGIN: begin
            if (begin_transaction_in) begin
               state_d = S_BUSY;
            end else if (error_in || (bcnt_q == BW_LAST)) begin
               state_d = S_IDLE;
               busy_d  = 1'b0;
            end else begin
               bcnt_d = bcnt_q + BW_W'(1);
            end
         end
         S_BUSY: begin
            if (end_transaction_in || error_in) begin
               state_d = S_IDLE;
               busy_d  = 1'b0;
`ifdef BUS_ARB_TIMEOUT_EN
            end else if (begin_transaction_in) begin
               wd_d = '0;
            end else if (wd_q == WD_LAST) begin
               abort_d = 1'b1;
               state_d = S_IDLE;
               busy_d  = 1'b0;
            end else begin
               wd_d = wd_q + WD_W'(1);
`endif
            end
         end
         default: begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         ptr_q   <= '0;
         owner_q <= '0;
         grant_q <= '0;
         busy_q  <= 1'b0;
         bcnt_q  <= '0;
`ifdef BUS_ARB_TIMEOUT_EN
         wd_q    <= '0;
         abort_q <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         owner_q <= owner_d;
         grant_q <= grant_d;
         busy_q  <= busy_d;
         bcnt_q  <= bcnt_d;
`ifdef BUS_ARB_TIMEOUT_EN
         wd_q    <= wd_d;
         abort_q <= abort_d;
`endif
      end
   end

   assign granted       = grant_q;
   assign active_master = owner_q;
   assign bus_busy      = busy_q;
   assign dbg_state_o   = state_q;
   assign dbg_ptr_o     = ptr_q;
`ifdef BUS_ARB_TIMEOUT_EN
   assign end_transaction_out = abort_q;
   assign timeout_error       = abort_q;
`else
   assign end_transaction_out = 1'b0;
   assign timeout_error       = 1'b0;
`endif

endmodule

// File: tb/tb_bus_rr_arbiter.sv
// Testbench for bus_rr_arbiter (4 masters, begin window 4, watchdog 16).
module tb_bus_rr_arbiter;

   localparam int N  = 4;
   localparam int BW = 4;
   localparam int TO = 16;

   logic         clock;
   logic         reset;
   logic [N-1:0] request;
   logic         begin_in;
   logic         end_in;
   logic         error_in;
   logic [N-1:0] granted;
   logic [1:0]   active_master;
   logic         bus_busy;
   logic         end_out;
   logic         timeout_error;
   logic [1:0]   dbg_state;
   logic [1:0]   dbg_ptr;

   int total = 0;
   int bad   = 0;

   logic [N-1:0] exp_q[$];

   typedef struct {
      logic [N-1:0] prev;
      logic [N-1:0] req;
      logic [N-1:0] exp_gnt;
      logic [1:0]   exp_idx;
      logic [1:0]   exp_ptr;
   } vec_t;

   vec_t vecs[10];

   bus_rr_arbiter #(
      .NUM_MASTERS   (N),
      .BEGIN_WINDOW  (BW),
      .TIMEOUT_CYCLES(TO)
   ) dut (
      .clock               (clock),
      .reset               (reset),
      .request             (request),
      .begin_transaction_in(begin_in),
      .end_transaction_in  (end_in),
      .error_in            (error_in),
      .granted             (granted),
      .active_master       (active_master),
      .bus_busy            (bus_busy),
      .end_transaction_out (end_out),
      .timeout_error       (timeout_error),
      .dbg_state_o         (dbg_state),
      .dbg_ptr_o           (dbg_ptr)
   );

   // ---------------- clock / reset ----------------
   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation still running at %0t", $time);
      $fatal(1);
   end

   // ---------------- driver tasks ----------------
   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic do_reset();
      reset    = 1'b1;
      request  = '0;
      begin_in = 1'b0;
      end_in   = 1'b0;
      error_in = 1'b0;
      step();
      step();
      #2;
      reset = 1'b0;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Returns to IDLE from WAIT_BEGIN by raising error_in. This is used
   // after a grant that is only there to move the priority pointer.
   task automatic abandon_grant();
      request = '0;
      step();
      error_in = 1'b1;
      step();
      error_in = 1'b0;
   endtask

   // ---------------- random-phase reference state ----------------
   int           mptr;
   logic [N-1:0] pend;
   int           wait_cnt[N];

   initial begin
      vecs[0] = '{4'b0000, 4'b0001, 4'b0001, 2'd0, 2'd1};
      vecs[1] = '{4'b0000, 4'b1010, 4'b0010, 2'd1, 2'd2};
      vecs[2] = '{4'b0000, 4'b1000, 4'b1000, 2'd3, 2'd0};
      vecs[3] = '{4'b0001, 4'b0001, 4'b0001, 2'd0, 2'd1};
      vecs[4] = '{4'b0001, 4'b0101, 4'b0100, 2'd2, 2'd3};
      vecs[5] = '{4'b0100, 4'b0111, 4'b0001, 2'd0, 2'd1};
      vecs[6] = '{4'b0100, 4'b1011, 4'b1000, 2'd3, 2'd0};
      vecs[7] = '{4'b1000, 4'b1110, 4'b0010, 2'd1, 2'd2};
      vecs[8] = '{4'b0010, 4'b0011, 4'b0001, 2'd0, 2'd1};
      vecs[9] = '{4'b0010, 4'b1111, 4'b0100, 2'd2, 2'd3};

      // ---- reset state ----
      do_reset();
      chk("rst_granted", granted, 0);
      chk("rst_busy", bus_busy, 0);
      chk("rst_active", active_master, 0);
      chk("rst_end_out", end_out, 0);
      chk("rst_timeout", timeout_error, 0);
      chk("rst_state", dbg_state, 0);
      chk("rst_ptr", dbg_ptr, 0);

      // ---- table: priority search from a given pointer ----
      for (int i = 0; i < 10; i++) begin
         do_reset();
         if (vecs[i].prev != '0) begin
            request = vecs[i].prev;
            step();
            abandon_grant();
         end
         request = vecs[i].req;
         step();
         chk("tbl_gnt", granted, vecs[i].exp_gnt);
         chk("tbl_idx", active_master, vecs[i].exp_idx);
         chk("tbl_ptr", dbg_ptr, vecs[i].exp_ptr);
         abandon_grant();
      end

      // ---- single requester ----
      do_reset();
      request = 4'b0100;
      step();
      chk("single_gnt", granted, 4'b0100);
      chk("single_busy", bus_busy, 1);
      chk("single_active", active_master, 2);
      request = '0;
      step();
      chk("single_gnt_pulse", granted, 0);
      chk("single_wait_state", dbg_state, 2);
      begin_in = 1'b1;
      step();
      begin_in = 1'b0;
      chk("single_busy_state", dbg_state, 3);
      repeat (7) step();
      chk("single_still_busy", bus_busy, 1);
      end_in = 1'b1;
      step();
      end_in = 1'b0;
      chk("single_busy_fall", bus_busy, 0);
      chk("single_idle", dbg_state, 0);
      chk("single_ptr", dbg_ptr, 3);

      // ---- round robin with all masters requesting ----
      do_reset();
      request = 4'b1111;
      for (int t = 0; t < 5; t++) begin
         logic [N-1:0] one;
         one = 1;
         step();
         chk("rr_gnt", granted, one << (t % N));
         step();
         begin_in = 1'b1;
         step();
         begin_in = 1'b0;
         step();
         end_in = 1'b1;
         step();
         end_in = 1'b0;
         chk("rr_closed", bus_busy, 0);
      end
      request = '0;
      step();

      // ---- no begin: window expiry, then pending master 2 ----
      do_reset();
      request = 4'b0110;
      step();
      chk("nobeg_gnt", granted, 4'b0010);
      request = 4'b0100;
      step();
      repeat (3) begin
         step();
         chk("nobeg_busy", bus_busy, 1);
      end
      step();
      chk("nobeg_expired", bus_busy, 0);
      chk("nobeg_idle", dbg_state, 0);
      step();
      chk("nobeg_next_gnt", granted, 4'b0100);
      abandon_grant();

      // ---- simultaneous end and error ----
      do_reset();
      request = 4'b0001;
      step();
      request = '0;
      step();
      begin_in = 1'b1;
      step();
      begin_in = 1'b0;
      step();
      end_in   = 1'b1;
      error_in = 1'b1;
      step();
      end_in   = 1'b0;
      error_in = 1'b0;
      chk("both_busy", bus_busy, 0);
      chk("both_state", dbg_state, 0);
      chk("both_timeout", timeout_error, 0);
      chk("both_end_out", end_out, 0);
      step();
      chk("both_stay_idle", dbg_state, 0);
      chk("both_no_gnt", granted, 0);

      // ---- watchdog ----
      do_reset();
      request = 4'b0010;
      step();
      request = '0;
      step();
      begin_in = 1'b1;
      step();
      begin_in = 1'b0;
`ifdef BUS_ARB_TIMEOUT_EN
      repeat (TO - 1) begin
         step();
         chk("wd_quiet", end_out, 0);
      end
      step();
      chk("wd_end_out", end_out, 1);
      chk("wd_timeout", timeout_error, 1);
      step();
      chk("wd_end_out_pulse", end_out, 0);
      chk("wd_timeout_pulse", timeout_error, 0);
      chk("wd_busy", bus_busy, 0);
`else
      repeat (100) step();
      chk("nowd_busy", bus_busy, 1);
      chk("nowd_state", dbg_state, 3);
      chk("nowd_end_out", end_out, 0);
      chk("nowd_timeout", timeout_error, 0);
      end_in = 1'b1;
      step();
      end_in = 1'b0;
      chk("nowd_closed", bus_busy, 0);
`endif

      // ---- async reset mid-BUSY ----
      do_reset();
      request = 4'b0100;
      step();
      request = '0;
      step();
      begin_in = 1'b1;
      step();
      begin_in = 1'b0;
      step();
      chk("arst_pre_active", active_master, 2);
      #3;
      reset = 1'b1;
      #1;
      chk("arst_granted", granted, 0);
      chk("arst_busy", bus_busy, 0);
      chk("arst_active", active_master, 0);
      chk("arst_state", dbg_state, 0);
      #1;
      reset   = 1'b0;
      request = 4'b1000;
      step();
      chk("arst_regrant", granted, 4'b1000);
      chk("arst_regrant_idx", active_master, 3);
      abandon_grant();

      // ---- randomized transactions against the reference model ----
      do_reset();
      mptr = 0;
      pend = '0;
      for (int m = 0; m < N; m++) wait_cnt[m] = 0;
      for (int t = 0; t < 40; t++) begin
         int           w;
         int           kind;
         int           d;
         int           len;
         int           ek;
         logic [N-1:0] one;
         one = 1;
         if (pend == '0) pend = N'($urandom_range(1, 15));
         request = pend;
         // The winner is the first requester found going upward from the
         // pointer and wrapping around.
         w = -1;
         for (int i = 0; i < N; i++)
            if (w < 0 && pend[(mptr + i) % N]) w = (mptr + i) % N;
         exp_q.push_back(one << w);
         step();
         chk("rnd_gnt", granted, exp_q.pop_front());
         chk("rnd_owner", active_master, w);
         chk("rnd_busy_at_grant", bus_busy, 1);
         chk("rnd_fair", (wait_cnt[w] <= N - 1), 1);
         for (int m = 0; m < N; m++) begin
            if (m == w) wait_cnt[m] = 0;
            else if (pend[m]) wait_cnt[m]++;
         end
         mptr    = (w + 1) % N;
         pend[w] = 1'b0;
         pend    = pend | (N'($urandom_range(0, 15)) & N'($urandom_range(0, 15)));
         request = pend;
         step();
         chk("rnd_gnt_pulse", granted, 0);
         chk("rnd_busy_grant_state", bus_busy, 1);
         kind = $urandom_range(0, 2);
         if (kind == 0) begin
            d = $urandom_range(1, BW - 1);
            repeat (d - 1) begin
               step();
               chk("rnd_busy_wait", bus_busy, 1);
            end
            begin_in = 1'b1;
            step();
            begin_in = 1'b0;
            chk("rnd_busy_begin", bus_busy, 1);
            len = $urandom_range(1, 6);
            repeat (len - 1) begin
               step();
               chk("rnd_busy_xfer", bus_busy, 1);
               chk("rnd_no_gnt_xfer", granted, 0);
            end
            ek = $urandom_range(0, 2);
            end_in   = (ek != 1);
            error_in = (ek != 0);
            step();
            end_in   = 1'b0;
            error_in = 1'b0;
            chk("rnd_closed", bus_busy, 0);
            chk("rnd_no_timeout", timeout_error, 0);
         end else if (kind == 1) begin
            repeat (BW - 1) begin
               step();
               chk("rnd_busy_nobeg", bus_busy, 1);
            end
            step();
            chk("rnd_nobeg_closed", bus_busy, 0);
         end else begin
            d = $urandom_range(1, BW);
            repeat (d - 1) begin
               step();
               chk("rnd_busy_preerr", bus_busy, 1);
            end
            error_in = 1'b1;
            step();
            error_in = 1'b0;
            chk("rnd_err_closed", bus_busy, 0);
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
